ising_sweep_controller: RTL
===========================

Name: ising_sweep_controller

Overview:
Sequences Metropolis Monte-Carlo sweeps over an on-chip N x N Ising spin lattice with periodic boundaries.
For each site it fetches the four neighbours and evaluates the spin-flip energy change dE. It then decides acceptance against host-supplied Boltzmann thresholds and a random-number stream, and writes the flipped spin back.
Updates use checkerboard order: all even-parity sites first, then all odd-parity sites.
The host loads and reads back the lattice through a simple word port while the block is idle.

Parameters:
LOG2_N, 4, log2 of lattice side N (N = 16, 256 sites); N must be even and at least 4
RND_W, 16, width of random numbers and thresholds
CNT_W, 32, width of flip counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a run when idle
num_sweeps  in  16  sweeps per run, sampled on accepted start
thr2  in  RND_W  accept threshold for dE = +2 (≈ exp(-2β)·2^RND_W)
thr4  in  RND_W  accept threshold for dE = +4
rnd  in  RND_W  random number
rnd_valid  in  1  rnd is valid
rnd_ready  out  1  rnd consumed this cycle when rnd_valid is also high
wr_en  in  1  host spin write; honoured only when idle
wr_addr  in  2*LOG2_N  site address = y*N + x
wr_data  in  1  spin value
rd_addr  in  2*LOG2_N  readback address
rd_data  out  1  spin at rd_addr, combinational
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
flip_count  out  CNT_W  accepted flips in current or last run
sweeps_done  out  16  completed sweeps in current or last run

Behaviour:
- Reset state:
  - FSM goes to IDLE.
  - All lattice bits are 0.
  - busy, done, rnd_ready, flip_count and sweeps_done are 0.
- Energy rule:
  - m = number of neighbours (left, right, top, bottom) equal to the centre spin.
  - dE = 2*m - 4, signed 8-bit, taking only the values -4, -2, 0, 2, 4.
  - Neighbour coordinates: left (x-1) mod N, right (x+1) mod N, top (y-1) mod N, bottom (y+1) mod N.
- Acceptance:
  - dE <= 0: accept unconditionally; no rnd is consumed.
  - dE = 2: accept iff rnd < thr2, one rnd consumed.
  - dE = 4: accept iff rnd < thr4, one rnd consumed.
  - Comparisons are unsigned. A threshold of 0 never accepts; 2^RND_W-1 accepts every rnd except the maximum value.
- Scan order:
  - Phase p is 0 or 1; counter k runs 0 .. N*N/2-1.
  - y = k / (N/2); x = 2*(k mod (N/2)) + ((y+p) mod 2).
  - One sweep is phase 0 followed by phase 1.
- FSM:
  - IDLE: on start, clear flip_count and sweeps_done, latch num_sweeps, and set busy.
    - If num_sweeps = 0, go to FINISH; otherwise go to FETCH with k = 0, p = 0.
  - FETCH (1 cycle): register the centre spin, 4 neighbours and the site address; compute dE.
  - DECIDE:
    - dE <= 0: accept in the same cycle.
    - dE > 0: hold rnd_ready = 1 until rnd_valid = 1; decide in the cycle the handshake completes.
    - rnd_ready is low in every other state.
  - WRITE (1 cycle):
    - If accepted, invert the spin and increment flip_count (saturating).
    - Then advance k.
    - At the end of a phase, toggle p.
    - At the end of phase 1, increment sweeps_done; go to FINISH if sweeps_done equals num_sweeps, else go to FETCH.
  - FINISH: done = 1 for one cycle, busy = 0, return to IDLE.
- Timing and concurrency:
  - Minimum 3 cycles per site without stall; a 16x16 sweep takes ≥768 cycles.
  - A write in WRITE is visible to the next FETCH (no forwarding hazard because of the sequential per-site update).
  - start while busy is ignored; num_sweeps changes mid-run have no effect.
  - wr_en while busy is ignored.
  - rd_addr reads are allowed at any time and return live state.
  - Reset mid-run aborts immediately, clears the lattice and all counters, and produces no done pulse.

Decomposition:
- Shared package ising_pkg holds:
  - FSM state enum (IDLE, FETCH, DECIDE, WRITE, FINISH).
  - Signed dE type (8-bit).
  - Constants DE_P2 = 2 and DE_P4 = 4.
  - Function neighbour_addr(x, y, dir) implementing the wrap.
- One natural sub-module: ising_accept_unit (combinational). It takes centre + neighbours, rnd, thr2, thr4 and outputs dE, need_rnd and accept.

Test Plan:
- Wrap / single defect, N=16, thr2 = thr4 = 0, rnd_valid = 1:
  - Setup: only (0,0) = 1.
  - (0,0) sees dE = -4 and flips to 0.
  - (1,0), (15,0), (0,1), (0,15) each evaluate dE = 4 and are rejected.
  - After one sweep: all spins 0, flip_count = 1, exactly 255 rnd handshakes.
- Checkerboard start spin = (x+y)&1, thr2 = thr4 = 0, num_sweeps = 1:
  - Phase 0 flips all 128 even sites; phase 1 sees dE = 4 everywhere and flips none.
  - Final: all ones, flip_count = 128, 128 rnd handshakes, done one cycle after the last WRITE.
- All-zero lattice, thr4 = 0xFFFF, rnd = 0, num_sweeps = 2:
  - Sweep 1: even sites flip (dE = 4 accepted), then odd sites flip (dE = -4). Lattice is all ones.
  - Sweep 2 does the same, returning the lattice to all zeros.
  - Final: flip_count = 512, sweeps_done = 2.
- rnd stall:
  - Hold rnd_valid = 0 for 10 cycles at the first dE > 0 site.
  - busy stays 1, the lattice is unchanged, and rnd_ready stays high.
  - Release → decision taken, FSM proceeds.
- num_sweeps = 0 → done one cycle after start (busy high for that cycle), lattice and counters unchanged except for the clear.
- Reset and host-port protection:
  - wr_en asserted during a run: no effect.
  - Reset asserted mid-sweep: next cycle busy = 0, flip_count = 0, all rd_data = 0, and no done pulse.

Source files
------------

// File: rtl/ising_pkg.sv
// Shared types, constants and the periodic-boundary neighbour address helper
// for the Ising sweep controller.
package ising_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECIDE,
      WRITE,
      FINISH
   } state_t;

   typedef logic signed [7:0] de_t;

   localparam de_t DE_P2 = 8'sd2;
   localparam de_t DE_P4 = 8'sd4;

   typedef enum logic [1:0] {
      DIR_LEFT,
      DIR_RIGHT,
      DIR_TOP,
      DIR_BOTTOM
   } dir_t;

   // Coordinates wrap modulo 2^log2n; the result is y*N + x in 16 bits.
   function automatic logic [15:0] neighbour_addr(input logic [7:0] x,
                                                  input logic [7:0] y,
                                                  input dir_t dir,
                                                  input int unsigned log2n);
      logic [7:0] mask;
      logic [7:0] nx;
      logic [7:0] ny;
      mask = 8'((16'd1 << log2n) - 16'd1);
      nx = x;
      ny = y;
      case (dir)
         DIR_LEFT:   nx = (x - 8'd1) & mask;
         DIR_RIGHT:  nx = (x + 8'd1) & mask;
         DIR_TOP:    ny = (y - 8'd1) & mask;
         DIR_BOTTOM: ny = (y + 8'd1) & mask;
         default:    nx = x;
      endcase
      return (16'(ny) << log2n) | 16'(nx);
   endfunction

endpackage

// File: rtl/ising_sweep_controller_if.sv
// Host, random-stream and status signals of the Ising sweep controller.
interface ising_sweep_controller_if #(
   parameter int LOG2_N = 4,
   parameter int RND_W  = 16,
   parameter int CNT_W  = 32
);
   logic                  start;
   logic [15:0]           num_sweeps;
   logic [RND_W-1:0]      thr2;
   logic [RND_W-1:0]      thr4;
   logic [RND_W-1:0]      rnd;
   logic                  rnd_valid;
   logic                  rnd_ready;
   logic                  wr_en;
   logic [2*LOG2_N-1:0]   wr_addr;
   logic                  wr_data;
   logic [2*LOG2_N-1:0]   rd_addr;
   logic                  rd_data;
   logic                  busy;
   logic                  done;
   logic [CNT_W-1:0]      flip_count;
   logic [15:0]           sweeps_done;

   modport master (
      output start, num_sweeps, thr2, thr4, rnd, rnd_valid,
             wr_en, wr_addr, wr_data, rd_addr,
      input  rnd_ready, rd_data, busy, done, flip_count, sweeps_done
   );

   modport slave (
      input  start, num_sweeps, thr2, thr4, rnd, rnd_valid,
             wr_en, wr_addr, wr_data, rd_addr,
      output rnd_ready, rd_data, busy, done, flip_count, sweeps_done
   );
endinterface

// File: rtl/ising_sweep_controller_accept_unit.sv
// Combinational Metropolis step: spin-flip energy change and acceptance
// against the Boltzmann thresholds.
module ising_accept_unit
   import ising_pkg::*;
#(
   parameter int RND_W = 16
) (
   input  logic             centre,
   input  logic [3:0]       nbr,
   input  logic [RND_W-1:0] rnd,
   input  logic [RND_W-1:0] thr2,
   input  logic [RND_W-1:0] thr4,
   output de_t              de,
   output logic             need_rnd,
   output logic             accept
);
   logic [3:0] eq;
   logic [2:0] m;

   always_comb begin
      eq = ~(nbr ^ {4{centre}});
      m  = 3'(eq[0]) + 3'(eq[1]) + 3'(eq[2]) + 3'(eq[3]);
      case (m)
         3'd0:    de = -8'sd4;
         3'd1:    de = -8'sd2;
         3'd2:    de = 8'sd0;
         3'd3:    de = DE_P2;
         default: de = DE_P4;
      endcase
      need_rnd = (de > 8'sd0);
      accept   = 1'b1;
      if (de == DE_P2) begin
         accept = (rnd < thr2);
      end else if (de == DE_P4) begin
         accept = (rnd < thr4);
      end
   end
endmodule

// File: rtl/ising_sweep_controller.sv
// Checkerboard Metropolis sweep sequencer over an on-chip N x N spin lattice
// with periodic boundaries; the host port owns the lattice while idle.
module ising_sweep_controller
   import ising_pkg::*;
#(
   parameter int LOG2_N = 4,
   parameter int RND_W  = 16,
   parameter int CNT_W  = 32
) (
   input  logic clk,
   input  logic reset,
   ising_sweep_controller_if.slave bus
);
   localparam int N     = 1 << LOG2_N;
   localparam int SITES = N * N;
   localparam int AW    = 2 * LOG2_N;
   localparam int KW    = AW - 1;
   localparam logic [KW-1:0] K_LAST = KW'(SITES / 2 - 1);

   state_t state, state_nxt;

   logic [SITES-1:0]  lattice;
   logic [KW-1:0]     k;
   logic              phase;
   logic [15:0]       sweeps_target;
   logic [15:0]       sweeps_done;
   logic [CNT_W-1:0]  flip_count;

   logic [LOG2_N-1:0] x_p0, y_p0;
   logic [3:0]        nbr_p0;
   logic              centre_p1;
   logic [3:0]        nbr_p1;
   logic [AW-1:0]     addr_p1;
   logic              accept_p2;

   de_t  de;
   logic need_rnd, accept;
   logic end_of_phase, end_of_run;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   ising_accept_unit #(.RND_W(RND_W)) u_accept (
      .centre   (centre_p1),
      .nbr      (nbr_p1),
      .rnd      (bus.rnd),
      .thr2     (bus.thr2),
      .thr4     (bus.thr4),
      .de       (de),
      .need_rnd (need_rnd),
      .accept   (accept)
   );

   assign end_of_phase = (k == K_LAST);
   assign end_of_run   = end_of_phase && phase && (16'(sweeps_done + 16'd1) == sweeps_target);

   // Stage p0: site coordinates from (k, phase) and wrapped neighbour fetch
   always_comb begin
      y_p0 = k[KW-1:LOG2_N-1];
      x_p0 = {k[LOG2_N-2:0], k[LOG2_N-1] ^ phase};
      for (int d = 0; d < 4; d++) begin
         nbr_p0[d] = lattice[AW'(neighbour_addr(8'(x_p0), 8'(y_p0), dir_t'(d), LOG2_N))];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = (bus.num_sweeps == 16'd0) ? FINISH : FETCH;
         FETCH:   state_nxt = DECIDE;
         DECIDE:  if (!need_rnd || bus.rnd_valid) state_nxt = WRITE;
         WRITE:   state_nxt = end_of_run ? FINISH : FETCH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy      = (state != IDLE);
      bus.done      = (state == FINISH);
      bus.rnd_ready = (state == DECIDE) && (de > 8'sd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         k             <= '0;
         phase         <= 1'b0;
         sweeps_done   <= '0;
         sweeps_target <= '0;
         flip_count    <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               k             <= '0;
               phase         <= 1'b0;
               sweeps_done   <= '0;
               sweeps_target <= bus.num_sweeps;
               flip_count    <= '0;
            end
            WRITE: begin
               if (accept_p2) flip_count <= sat_inc(flip_count);
               k <= end_of_phase ? '0 : k + KW'(1);
               if (end_of_phase) begin
                  phase <= ~phase;
                  if (phase) sweeps_done <= sweeps_done + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Stage p1: registered site snapshot; stage p2: registered decision
   always_ff @(posedge clk) begin
      if (state == FETCH) begin
         centre_p1 <= lattice[{y_p0, x_p0}];
         nbr_p1    <= nbr_p0;
         addr_p1   <= {y_p0, x_p0};
      end
      if (state == DECIDE) accept_p2 <= accept;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lattice <= '0;
      end else if (state == IDLE && bus.wr_en) begin
         lattice[bus.wr_addr] <= bus.wr_data;
      end else if (state == WRITE && accept_p2) begin
         lattice[addr_p1] <= ~lattice[addr_p1];
      end
   end

   assign bus.rd_data     = lattice[bus.rd_addr];
   assign bus.flip_count  = flip_count;
   assign bus.sweeps_done = sweeps_done;

endmodule
